// File: rtl/issue_select_pkg.sv
// -----------------------------------------------------------------------------
// issue_select_pkg
//   Shared sizing constants and index/latency types for the issue scheduler.
//   RS_ENTRIES : reservation-station entries (power of two)
//   NUM_FUS    : functional units served by the scheduler
//   LAT_W      : width of an entry's execution-latency field
// -----------------------------------------------------------------------------
package issue_select_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int NUM_FUS    = 2;
  localparam int LAT_W      = 4;

  localparam int IDX_W = $clog2(RS_ENTRIES);
  // A single FU still needs a 1-bit selector field per entry.
  localparam int FU_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

  typedef logic [IDX_W-1:0] rs_idx_t;
  typedef logic [FU_W-1:0]  fu_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

endpackage : issue_select_pkg

// File: rtl/issue_select_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Round-robin priority picker: returns the first set bit of `mask` found by
//   scanning upward from `ptr`, wrapping from N-1 back to 0.
//   mask  in  N : candidate entries
//   ptr   in  W : scan start position
//   valid out 1 : at least one candidate was found
//   idx   out W : index of the chosen candidate (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // N is a power of two, so the W-bit add wraps exactly at N.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise an unassigned path infers a latch.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + W'(i);
      if (!valid && mask[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/issue_select.sv
// -----------------------------------------------------------------------------
// issue_select
//   Per-FU issue scheduler. Each cycle every free FU picks one ready, not yet
//   in-flight RS entry targeting it (round-robin from that FU's pointer), then
//   counts down the entry's latency and pulses completion on the last cycle.
//
//   clk         in  1                 : rising-edge clock
//   rst         in  1                 : synchronous active-high reset
//   flush       in  1                 : squash all in-flight work (pointers kept)
//   reqs        in  RS_ENTRIES        : ready mask from wakeup
//   entry_fu    in  RS_ENTRIES*FU_W   : target FU per entry
//   entry_lat   in  RS_ENTRIES*LAT_W  : execution latency per entry (0 acts as 1)
//   grant_valid out NUM_FUS           : FU f issues this cycle
//   grant       out NUM_FUS*IDX_W     : entry issued to FU f (0 when idle)
//   fu_busy     out NUM_FUS           : FU f latency counter nonzero
//   done_valid  out NUM_FUS           : FU f completes its entry this cycle
//   done_entry  out NUM_FUS*IDX_W     : entry completing on FU f
// -----------------------------------------------------------------------------
module issue_select #(
  parameter int RS_ENTRIES = issue_select_pkg::RS_ENTRIES,
  parameter int NUM_FUS    = issue_select_pkg::NUM_FUS,
  parameter int LAT_W      = issue_select_pkg::LAT_W,
  parameter int IDX_W      = $clog2(RS_ENTRIES),
  parameter int FU_W       = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [RS_ENTRIES-1:0]       reqs,
  input  logic [RS_ENTRIES*FU_W-1:0]  entry_fu,
  input  logic [RS_ENTRIES*LAT_W-1:0] entry_lat,
  output logic [NUM_FUS-1:0]          grant_valid,
  output logic [NUM_FUS*IDX_W-1:0]    grant,
  output logic [NUM_FUS-1:0]          fu_busy,
  output logic [NUM_FUS-1:0]          done_valid,
  output logic [NUM_FUS*IDX_W-1:0]    done_entry
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LAT_W-1:0]      cnt_q    [NUM_FUS];
  logic [LAT_W-1:0]      cnt_d    [NUM_FUS];
  logic [IDX_W-1:0]      cur_q    [NUM_FUS];
  logic [IDX_W-1:0]      cur_d    [NUM_FUS];
  logic [IDX_W-1:0]      rr_ptr_q [NUM_FUS];
  logic [IDX_W-1:0]      rr_ptr_d [NUM_FUS];
  logic [RS_ENTRIES-1:0] inflight_q;
  logic [RS_ENTRIES-1:0] inflight_d;

  // ---------------------------------------------------------------------------
  // Eligibility and per-FU pickers
  // ---------------------------------------------------------------------------
  logic [NUM_FUS-1:0][RS_ENTRIES-1:0] elig;
  logic [NUM_FUS-1:0]                 pick_valid;
  logic [IDX_W-1:0]                   pick_idx [NUM_FUS];
  logic [NUM_FUS-1:0]                 fu_free;
  logic [LAT_W-1:0]                   sel_lat;

  // Entries whose FU field is >= NUM_FUS never match any f, so they are
  // simply never granted.
  always_comb begin
    elig = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int e = 0; e < RS_ENTRIES; e++) begin
        elig[f][e] = reqs[e] && !inflight_q[e] &&
                     (entry_fu[e*FU_W +: FU_W] == FU_W'(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
    rr_pick #(
      .N (RS_ENTRIES),
      .W (IDX_W)
    ) u_pick (
      .mask  (elig[f]),
      .ptr   (rr_ptr_q[f]),
      .valid (pick_valid[f]),
      .idx   (pick_idx[f])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational from current inputs and registered state. They are
  // held at zero while rst is high so nothing is issued or retired during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = '0;
    grant       = '0;
    fu_busy     = '0;
    done_valid  = '0;
    done_entry  = '0;
    fu_free     = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      // A counter at 1 finishes this cycle, so the FU can accept back-to-back.
      fu_free[f] = (cnt_q[f] <= LAT_W'(1));
      if (!rst) begin
        grant_valid[f] = fu_free[f] && pick_valid[f];
        if (grant_valid[f]) begin
          grant[f*IDX_W +: IDX_W] = pick_idx[f];
        end
        fu_busy[f]                   = (cnt_q[f] != '0);
        done_valid[f]                = (cnt_q[f] == LAT_W'(1));
        done_entry[f*IDX_W +: IDX_W] = cur_q[f];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    sel_lat    = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      cnt_d[f]    = cnt_q[f];
      cur_d[f]    = cur_q[f];
      rr_ptr_d[f] = rr_ptr_q[f];
    end

    // Retire first, then issue: a completing entry is still in flight and so
    // cannot be the one granted, and the new set must survive the old clear.
    for (int f = 0; f < NUM_FUS; f++) begin
      if (done_valid[f]) begin
        inflight_d[cur_q[f]] = 1'b0;
      end
    end

    for (int f = 0; f < NUM_FUS; f++) begin
      if (grant_valid[f]) begin
        sel_lat                  = entry_lat[pick_idx[f]*LAT_W +: LAT_W];
        cnt_d[f]                 = (sel_lat == '0) ? LAT_W'(1) : sel_lat;
        cur_d[f]                 = pick_idx[f];
        inflight_d[pick_idx[f]]  = 1'b1;
        rr_ptr_d[f]              = pick_idx[f] + IDX_W'(1);
      end else if (cnt_q[f] != '0) begin
        cnt_d[f] = cnt_q[f] - LAT_W'(1);
      end
    end

    // Flush discards this cycle's grants and completions; only the fairness
    // pointers are kept.
    if (flush) begin
      inflight_d = '0;
      for (int f = 0; f < NUM_FUS; f++) begin
        cnt_d[f]    = '0;
        cur_d[f]    = '0;
        rr_ptr_d[f] = rr_ptr_q[f];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      // NOTE: these per-FU arrays are a handful of flops, not a RAM, so they
      // are reset like any other control state.
      inflight_q <= '0;
      for (int f = 0; f < NUM_FUS; f++) begin
        cnt_q[f]    <= '0;
        cur_q[f]    <= '0;
        rr_ptr_q[f] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      for (int f = 0; f < NUM_FUS; f++) begin
        cnt_q[f]    <= cnt_d[f];
        cur_q[f]    <= cur_d[f];
        rr_ptr_q[f] <= rr_ptr_d[f];
      end
    end
  end

endmodule : issue_select

// File: tb/tb_issue_select.sv
// -----------------------------------------------------------------------------
// tb_issue_select
//   Directed, table-driven bench for issue_select. Each table row is one clock
//   cycle: inputs are driven after the falling edge, outputs are compared 1ns
//   later, and state advances at the following rising edge. A short hand-coded
//   sequence at the end covers reset taking priority over flush.
// -----------------------------------------------------------------------------
module tb_issue_select;
  import issue_select_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  logic [RS_ENTRIES-1:0]       reqs;
  logic [RS_ENTRIES*FU_W-1:0]  entry_fu;
  logic [RS_ENTRIES*LAT_W-1:0] entry_lat;
  logic [NUM_FUS-1:0]          grant_valid;
  logic [NUM_FUS*IDX_W-1:0]    grant;
  logic [NUM_FUS-1:0]          fu_busy;
  logic [NUM_FUS-1:0]          done_valid;
  logic [NUM_FUS*IDX_W-1:0]    done_entry;

  always #5 clk = ~clk;

  issue_select dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .reqs        (reqs),
    .entry_fu    (entry_fu),
    .entry_lat   (entry_lat),
    .grant_valid (grant_valid),
    .grant       (grant),
    .fu_busy     (fu_busy),
    .done_valid  (done_valid),
    .done_entry  (done_entry)
  );

  typedef struct {
    string                 name;
    logic                  rst;
    logic                  flush;
    logic [7:0]            reqs;
    logic [7:0]            fu;
    logic [31:0]           lat;
    bit                    chk;
    logic [1:0]            gv;
    rs_idx_t               g0;
    rs_idx_t               g1;
    logic [1:0]            busy;
    logic [1:0]            dv;
    rs_idx_t               d0;
    rs_idx_t               d1;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string name, input logic r, input logic fl,
                     input logic [7:0] rq, input logic [7:0] fu,
                     input logic [31:0] lat, input bit chk,
                     input logic [1:0] gv, input rs_idx_t g0, input rs_idx_t g1,
                     input logic [1:0] busy, input logic [1:0] dv,
                     input rs_idx_t d0, input rs_idx_t d1);
    vec_t v;
    v.name = name; v.rst = r; v.flush = fl; v.reqs = rq; v.fu = fu; v.lat = lat;
    v.chk = chk; v.gv = gv; v.g0 = g0; v.g1 = g1; v.busy = busy; v.dv = dv;
    v.d0 = d0; v.d1 = d1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] gv,
                            input rs_idx_t g0, input rs_idx_t g1,
                            input logic [1:0] busy, input logic [1:0] dv,
                            input rs_idx_t d0, input rs_idx_t d1);
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    check({tag, ".grant"},       32'(grant),       32'({g1, g0}));
    check({tag, ".fu_busy"},     32'(fu_busy),     32'(busy));
    check({tag, ".done_valid"},  32'(done_valid),  32'(dv));
    check({tag, ".done_entry"},  32'(done_entry),  32'({d1, d0}));
  endtask

  localparam logic [31:0] L1 = 32'h1111_1111;

  initial begin
    rst = 1'b1; flush = 1'b0; reqs = '0; entry_fu = '0; entry_lat = L1;

    //   name          rst fl reqs   fu     lat           chk gv  g0 g1 busy dv  d0 d1
    // Reset held two cycles with every entry requesting.
    add("rst0",        1, 0, 8'hFF, 8'h00, L1,           0, 0,  0, 0, 0,   0,  0, 0);
    add("rst1",        1, 0, 8'hFF, 8'h00, L1,           1, 0,  0, 0, 0,   0,  0, 0);
    // Round-robin on FU0, entries {0,1,3}, latency 1: grants 0,1,3,0,1.
    add("rr0",         0, 0, 8'h0B, 8'h00, L1,           1, 1,  0, 0, 0,   0,  0, 0);
    add("rr1",         0, 0, 8'h0B, 8'h00, L1,           1, 1,  1, 0, 1,   1,  0, 0);
    add("rr2",         0, 0, 8'h0B, 8'h00, L1,           1, 1,  3, 0, 1,   1,  1, 0);
    add("rr3",         0, 0, 8'h0B, 8'h00, L1,           1, 1,  0, 0, 1,   1,  3, 0);
    add("rr4",         0, 0, 8'h0B, 8'h00, L1,           1, 1,  1, 0, 1,   1,  0, 0);
    add("rr_drain",    0, 0, 8'h00, 8'h00, L1,           1, 0,  0, 0, 1,   1,  1, 0);
    add("idle1",       0, 0, 8'h00, 8'h00, L1,           1, 0,  0, 0, 0,   0,  1, 0);
    // Multi-cycle FU1: entry 2 latency 3 at T, entry 5 (latency 2) from T+1.
    add("mc_t0",       0, 0, 8'h04, 8'h24, 32'h1121_1311, 1, 2, 0, 2, 0,   0,  1, 0);
    add("mc_t1",       0, 0, 8'h24, 8'h24, 32'h1121_1311, 1, 0, 0, 0, 2,   0,  1, 2);
    add("mc_t2",       0, 0, 8'h24, 8'h24, 32'h1121_1311, 1, 0, 0, 0, 2,   0,  1, 2);
    add("mc_t3",       0, 0, 8'h24, 8'h24, 32'h1121_1311, 1, 2, 0, 5, 2,   2,  1, 2);
    add("mc_t4",       0, 0, 8'h00, 8'h24, 32'h1121_1311, 1, 0, 0, 0, 2,   0,  1, 5);
    add("mc_t5",       0, 0, 8'h00, 8'h24, 32'h1121_1311, 1, 0, 0, 0, 2,   2,  1, 5);
    // Dual issue: entry 4 on FU0 and entry 6 on FU1 in the same cycle.
    add("dual",        0, 0, 8'h50, 8'h40, L1,           1, 3,  4, 6, 0,   0,  1, 5);
    add("dual_done",   0, 0, 8'h00, 8'h40, L1,           1, 0,  0, 0, 3,   3,  4, 6);
    add("idle2",       0, 0, 8'h00, 8'h40, L1,           1, 0,  0, 0, 0,   0,  4, 6);
    // No double issue: entry 3 latency 4 keeps requesting.
    add("ndi_t0",      0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 1, 3, 0, 0,   0,  4, 6);
    add("ndi_t1",      0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 0, 0, 0, 1,   0,  3, 6);
    add("ndi_t2",      0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 0, 0, 0, 1,   0,  3, 6);
    add("ndi_t3",      0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 0, 0, 0, 1,   0,  3, 6);
    add("ndi_done",    0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 0, 0, 0, 1,   1,  3, 6);
    add("ndi_regrant", 0, 0, 8'h08, 8'h40, 32'h1111_4111, 1, 1, 3, 0, 0,   0,  3, 6);
    // Flush with FU0 cnt=3 and FU1 cnt=2 (entry 6, latency 2, issued below).
    add("fl_setup",    0, 0, 8'h40, 8'h40, 32'h1211_4111, 1, 2, 0, 6, 1,   0,  3, 6);
    add("fl_cycle",    0, 1, 8'h00, 8'h40, 32'h1211_4111, 1, 0, 0, 0, 3,   0,  3, 6);
    add("post_fl0",    0, 0, 8'h00, 8'h40, L1,           1, 0,  0, 0, 0,   0,  0, 0);
    add("post_fl1",    0, 0, 8'h00, 8'h40, L1,           1, 0,  0, 0, 0,   0,  0, 0);
    add("post_fl2",    0, 0, 8'h00, 8'h40, L1,           1, 0,  0, 0, 0,   0,  0, 0);
    // Pointers survived the flush (FU0 at 4 -> picks 5, FU1 at 7 -> picks 7);
    // entry 5 has latency 0, which behaves as 1.
    add("ptr_kept",    0, 0, 8'hA6, 8'h84, 32'h1101_1111, 1, 3, 5, 7, 0,   0,  0, 0);
    add("lat0_done",   0, 0, 8'h00, 8'h84, L1,           1, 0,  0, 0, 3,   3,  5, 7);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      reqs      = vecs[i].reqs;
      entry_fu  = vecs[i].fu;
      entry_lat = vecs[i].lat;
      #1;
      if (vecs[i].chk) begin
        check_outs(vecs[i].name, vecs[i].gv, vecs[i].g0, vecs[i].g1,
                   vecs[i].busy, vecs[i].dv, vecs[i].d0, vecs[i].d1);
      end
    end

    // rst together with flush: reset wins and clears the FU0 pointer (6 -> 0).
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; reqs = 8'h60; entry_fu = 8'h00; entry_lat = L1;
    #1;
    check_outs("rst_flush", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    #1;
    // Entries 5 and 6 both request; a reset pointer picks 5, a kept one 6.
    check_outs("after_rst", 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    reqs = 8'h00;
    #1;
    check_outs("after_rst_done", 0, 0, 0, 1, 1, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_issue_select
